// File: rtl/temporizador_pkg.sv
// Shared FSM state encoding and synchroniser constants for the tick timer.
// Pure declarations; no logic, no latency.
package temporizador_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CONTANDO  = 2'd1,
    PAUSADO   = 2'd2,
    CONCLUIDO = 2'd3
  } estado_t;

  localparam int SYNC_ESTAGIOS = 2;
  localparam int ARMAR_CICLOS  = 3;

endpackage

// File: rtl/sincronizador_borda.sv
// Brings one slow asynchronous clock into clk and emits a one-cycle tick per rising edge.
// Tick appears in the cycle after the third clk edge that sees the input high; no backpressure.
module sincronizador_borda
  import temporizador_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic entrada,
  output logic tick
);

  localparam int ARM_W = $clog2(ARMAR_CICLOS + 1);

  logic [SYNC_ESTAGIOS-1:0] sinc;
  logic                     anterior;
  logic [ARM_W-1:0]         arm_cnt;
  logic                     armado;

  // Holding off the first edges hides an input that was already high at reset.
  assign armado = (arm_cnt == ARM_W'(ARMAR_CICLOS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sinc     <= '0;
      anterior <= 1'b0;
      arm_cnt  <= '0;
      tick     <= 1'b0;
    end else begin
      sinc     <= {sinc[SYNC_ESTAGIOS-2:0], entrada};
      anterior <= sinc[SYNC_ESTAGIOS-1];
      if (!armado) begin
        arm_cnt <= arm_cnt + ARM_W'(1);
      end
      tick     <= sinc[SYNC_ESTAGIOS-1] & ~anterior & armado;
    end
  end

endmodule

// File: rtl/temporizador_de_ticks.sv
// Interval timer decrementing on ticks derived from two slow divided clocks, all on clk.
// State/count update one cycle after a request or tick; no backpressure, requests are levels.
module temporizador_de_ticks
  import temporizador_pkg::*;
#(
  parameter int LARGURA      = 8,
  parameter bit FONTE_PADRAO = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_lento_a,
  input  logic               clk_lento_b,
  input  logic               sel_fonte,
  input  logic               iniciar,
  input  logic               pausar,
  input  logic               limpar,
  input  logic [LARGURA-1:0] valor_carga,
  output logic               tick_a,
  output logic               tick_b,
  output logic [LARGURA-1:0] contagem,
  output logic [1:0]         estado,
  output logic               ativo,
  output logic               concluido
);

  estado_t            est, est_nxt;
  logic [LARGURA-1:0] cont_nxt;
  logic               conc_nxt;
  logic               tick_sel;

  sincronizador_borda u_sinc_a (.clk(clk), .rst_n(rst_n), .entrada(clk_lento_a), .tick(tick_a));
  sincronizador_borda u_sinc_b (.clk(clk), .rst_n(rst_n), .entrada(clk_lento_b), .tick(tick_b));

  assign tick_sel = (sel_fonte ^ FONTE_PADRAO) ? tick_b : tick_a;

  always_comb begin
    est_nxt  = est;
    cont_nxt = contagem;
    conc_nxt = 1'b0;
    if (limpar) begin
      est_nxt  = OCIOSO;
      cont_nxt = '0;
    end else begin
      case (est)
        OCIOSO, CONCLUIDO: begin
          if (iniciar) begin
            cont_nxt = valor_carga;
            if (valor_carga == '0) begin
              est_nxt  = CONCLUIDO;
              // A held start with a zero load must not pulse back-to-back.
              conc_nxt = ~concluido;
            end else begin
              est_nxt = CONTANDO;
            end
          end
        end
        CONTANDO: begin
          if (pausar) begin
            est_nxt = PAUSADO;
          end else if (tick_sel) begin
            if (contagem > LARGURA'(1)) begin
              cont_nxt = contagem - LARGURA'(1);
            end else if (contagem == LARGURA'(1)) begin
              cont_nxt = '0;
              est_nxt  = CONCLUIDO;
              conc_nxt = 1'b1;
            end
          end
        end
        PAUSADO: begin
          if (!pausar && iniciar) begin
            est_nxt = CONTANDO;
          end
        end
        default: est_nxt = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      est       <= OCIOSO;
      contagem  <= '0;
      concluido <= 1'b0;
    end else begin
      est       <= est_nxt;
      contagem  <= cont_nxt;
      concluido <= conc_nxt;
    end
  end

  assign estado = est;
  assign ativo  = (est == CONTANDO);

endmodule

// File: tb/tb_temporizador_de_ticks.sv
// Directed bench: expected counts go through a scoreboard queue, every check is an immediate assertion.
module tb_temporizador_de_ticks;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_lento_a = 1'b1;
  logic       clk_lento_b = 1'b0;
  logic       sel_fonte = 1'b0;
  logic       iniciar = 1'b0;
  logic       pausar = 1'b0;
  logic       limpar = 1'b0;
  logic [7:0] valor_carga = 8'd0;
  logic       tick_a, tick_b, ativo, concluido;
  logic [7:0] contagem;
  logic [1:0] estado;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ta = 0, n_tb = 0, n_conc = 0;
  int base_ta, base_tb, base_conc;
  logic [31:0] exp_q[$];

  temporizador_de_ticks #(.LARGURA(8), .FONTE_PADRAO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .clk_lento_a(clk_lento_a), .clk_lento_b(clk_lento_b),
    .sel_fonte(sel_fonte), .iniciar(iniciar), .pausar(pausar), .limpar(limpar),
    .valor_carga(valor_carga), .tick_a(tick_a), .tick_b(tick_b), .contagem(contagem),
    .estado(estado), .ativo(ativo), .concluido(concluido)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tick_a)    n_ta++;
    if (tick_b)    n_tb++;
    if (concluido) n_conc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic sb_push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulso(input bit fonte_b);
    if (fonte_b) clk_lento_b = 1'b1; else clk_lento_a = 1'b1;
    ciclos(6);
    if (fonte_b) clk_lento_b = 1'b0; else clk_lento_a = 1'b0;
    ciclos(6);
  endtask

  task automatic carregar(input logic [7:0] v);
    valor_carga = v;
    iniciar = 1'b1;
    ciclos(1);
    iniciar = 1'b0;
  endtask

  initial begin
    // 1: reset with clk_lento_a already high
    ciclos(2);
    chk("reset_estado", estado, 0);
    chk("reset_contagem", contagem, 0);
    chk("reset_ativo", ativo, 0);
    rst_n = 1'b1;
    ciclos(20);
    chk("no_spurious_tick_a", n_ta, 0);
    chk("idle_estado", estado, 0);
    chk("idle_contagem", contagem, 0);

    // 2: tick latency and single tick for a long high phase
    clk_lento_a = 1'b0;
    ciclos(5);
    base_ta = n_ta;
    clk_lento_a = 1'b1;
    ciclos(1); chk("lat_n", tick_a, 0);
    ciclos(1); chk("lat_n1", tick_a, 0);
    ciclos(1); chk("lat_n2", tick_a, 1);
    ciclos(1); chk("lat_n3", tick_a, 0);
    ciclos(46);
    clk_lento_a = 1'b0;
    ciclos(6);
    chk("one_tick_long_high", n_ta - base_ta, 1);

    // 3: count 3 down to 0 on source A
    sel_fonte = 1'b0;
    base_conc = n_conc;
    carregar(8'd3);
    chk("load3_estado", estado, 1);
    chk("load3_ativo", ativo, 1);
    sb_push(2); sb_push(1); sb_push(0);
    for (int i = 0; i < 3; i++) begin
      pulso(1'b0);
      sb_check("count3", contagem);
    end
    chk("count3_concluido_once", n_conc - base_conc, 1);
    chk("count3_estado", estado, 3);
    chk("count3_ativo", ativo, 0);

    // 4: pause coinciding with a tick
    carregar(8'd5);
    sb_push(4);
    pulso(1'b0);
    sb_check("pause_pre", contagem);
    clk_lento_a = 1'b1;
    ciclos(3);
    chk("pause_tick_present", tick_a, 1);
    pausar = 1'b1;
    ciclos(1);
    pausar = 1'b0;
    chk("pause_estado", estado, 2);
    sb_push(4);
    sb_check("pause_tick_lost", contagem);
    ciclos(3);
    clk_lento_a = 1'b0;
    ciclos(6);
    pulso(1'b0);
    pulso(1'b0);
    sb_push(4);
    sb_check("paused_ignores_ticks", contagem);
    chk("paused_estado", estado, 2);
    carregar(8'd99);
    chk("resume_estado", estado, 1);
    sb_push(4);
    sb_check("resume_keeps_count", contagem);
    pulso(1'b0);
    sb_push(3);
    sb_check("resume_tick", contagem);

    // 5: zero load goes straight to CONCLUIDO
    limpar = 1'b1; ciclos(1); limpar = 1'b0;
    chk("clear_estado", estado, 0);
    carregar(8'd0);
    chk("zero_estado", estado, 3);
    chk("zero_concluido", concluido, 1);
    chk("zero_contagem", contagem, 0);
    ciclos(1);
    chk("zero_concluido_drop", concluido, 0);

    // 6a: clear together with a tick at count 7
    carregar(8'd8);
    pulso(1'b0);
    sb_push(7);
    sb_check("clr_pre", contagem);
    clk_lento_a = 1'b1;
    ciclos(3);
    limpar = 1'b1;
    ciclos(1);
    limpar = 1'b0;
    chk("clr_tick_estado", estado, 0);
    chk("clr_tick_contagem", contagem, 0);
    ciclos(3);
    clk_lento_a = 1'b0;
    ciclos(6);

    // 6b: asynchronous reset mid-count
    carregar(8'd9);
    pulso(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_estado", estado, 0);
    chk("arst_contagem", contagem, 0);
    chk("arst_ativo", ativo, 0);
    chk("arst_concluido", concluido, 0);
    ciclos(2);
    rst_n = 1'b1;
    ciclos(5);

    // 6c: source B selected
    sel_fonte = 1'b1;
    carregar(8'd4);
    base_tb = n_tb;
    pulso(1'b0);
    sb_push(4);
    sb_check("selb_ignores_a", contagem);
    pulso(1'b1);
    sb_push(3);
    sb_check("selb_tick1", contagem);
    pulso(1'b1);
    sb_push(2);
    sb_check("selb_tick2", contagem);
    chk("selb_tick_count", n_tb - base_tb, 2);
    chk("selb_estado", estado, 1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/temporizador_de_ticks.md
Name: temporizador_de_ticks

Overview:
Consumes the two slow divided clocks from the ripple clock divider (divide-by-2^28 and divide-by-2^14 taps) and brings them into the main `clk` domain.
- Each slow input gets a 2-flop synchroniser and a rising-edge detector, producing one-cycle tick enables.
- A programmable down-counter with a start/pause/clear FSM uses the selected tick to time intervals for the system control logic.
- No logic downstream of this block clocks on divided clocks; everything runs on `clk`.

Parameters:
- `LARGURA`, 8, width of the load value and the count.
- `FONTE_PADRAO`, 0, tick source used when `sel_fonte`=0 (0=`clk_lento_a`, 1=`clk_lento_b`).

Ports:
- `clk` input 1: main system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `clk_lento_a` input 1: slow divided clock (div 2^28 tap), asynchronous to `clk`.
- `clk_lento_b` input 1: slow divided clock (div 2^14 tap), asynchronous to `clk`.
- `sel_fonte` input 1: 0 = source `FONTE_PADRAO`, 1 = the other source.
- `iniciar` input 1: start/resume/reload request, level sampled each cycle.
- `pausar` input 1: pause request.
- `limpar` input 1: synchronous clear.
- `valor_carga` input `LARGURA`: count loaded on start.
- `tick_a` output 1: one-cycle pulse per rising edge of `clk_lento_a`.
- `tick_b` output 1: one-cycle pulse per rising edge of `clk_lento_b`.
- `contagem` output `LARGURA`: current remaining count.
- `estado` output 2: FSM state encoding.
- `ativo` output 1: high while in CONTANDO.
- `concluido` output 1: one-cycle pulse on reaching zero.

Behaviour:

Clocking and reset:
- Single clock domain `clk`.
- `rst_n` low (asynchronous) clears all flops: sync stages, edge registers, arm counters, `tick_a`, `tick_b`, `contagem`, `concluido`, and the FSM (OCIOSO).
- Outputs after reset: `estado`=OCIOSO, `ativo`=0.

Synchroniser and edge detector, per input:
- Chain s1 -> s2 -> s3, all reset to 0.
- Tick register = s2 & ~s3 & armado.
- `armado` is 0 for the first 3 `clk` edges after reset release, then 1. This prevents a spurious tick when the input is already high at reset.
- Latency: if edge N is the first `clk` edge sampling the input high, the tick is high exactly during the cycle after edge N+2. It is one cycle wide regardless of how long the input stays high.
- A high phase shorter than one `clk` period may be missed; this is acceptable because the inputs are slow.

Tick selection:
- `tick_sel` = `tick_a` or `tick_b` per `sel_fonte`/`FONTE_PADRAO`.
- A change of `sel_fonte` takes effect on the next cycle. A tick in flight on the deselected source is dropped.

FSM states: OCIOSO=0, CONTANDO=1, PAUSADO=2, CONCLUIDO=3.
- Global priority: `limpar` > `pausar` > `iniciar` > `tick_sel`.
- `limpar` in any state: next state OCIOSO, `contagem`=0, `concluido`=0.
- OCIOSO + `iniciar`:
  - `contagem` <= `valor_carga`, go to CONTANDO.
  - If `valor_carga`=0, go straight to CONCLUIDO with a `concluido` pulse.
  - `pausar` is ignored in OCIOSO.
- CONTANDO:
  - `pausar`: go to PAUSADO, count frozen.
  - Else `tick_sel` with `contagem`>1: decrement.
  - Else `tick_sel` with `contagem`=1: `contagem` <= 0, go to CONCLUIDO, `concluido`=1 for one cycle.
  - `iniciar` in CONTANDO has no effect; there is no reload mid-run.
- PAUSADO:
  - Ticks are ignored.
  - `iniciar` without `pausar`: back to CONTANDO with the count preserved. The first tick counts from the next cycle.
- CONCLUIDO:
  - Holds `contagem`=0.
  - `iniciar` reloads as in OCIOSO.
  - `pausar` is ignored.
- Same-cycle conflicts:
  - Tick together with `pausar` in CONTANDO: pause wins and the tick is lost.
  - Tick together with `limpar`: clear wins.

Output and arithmetic rules:
- `ativo` = (`estado`==CONTANDO).
- `concluido` is registered and never asserts for two consecutive cycles.
- Decrement never wraps below 0.

Reset mid-operation: an asynchronous reset aborts immediately, with all outputs at their reset values in the same cycle.

Decomposition:
- Shared package `temporizador_pkg`:
  - state constants OCIOSO/CONTANDO/PAUSADO/CONCLUIDO (2-bit);
  - `SYNC_ESTAGIOS`=2;
  - `ARMAR_CICLOS`=3.
- One sub-module, `sincronizador_borda` (2-flop sync, edge register, arm counter, registered tick), instantiated twice.
- Top level holds the selection mux, the FSM and the counter.

Test Plan:
1. Reset release with `clk_lento_a` held high -> `tick_a` stays 0 for 20 cycles, `estado`=0, `contagem`=0.
2. `clk_lento_a` rises, first sampled at edge N -> `tick_a`=1 only in the cycle after N+2. A 50-cycle high phase still gives exactly 1 tick.
3. `valor_carga`=3, `iniciar` pulse, `sel_fonte`=0, 3 ticks on A -> `contagem` 3->2->1->0, `concluido` pulses once with the third decrement, `estado`=3, `ativo`=0.
4. `valor_carga`=5, count to 4, then `pausar` in the same cycle as a tick -> `contagem` stays 4 in PAUSADO; 2 further ticks ignored; `iniciar` -> CONTANDO, next tick gives 3.
5. `valor_carga`=0 plus `iniciar` -> CONCLUIDO the next cycle, `concluido`=1 for one cycle, `contagem`=0.
6. While counting at 7, `limpar` together with a tick -> OCIOSO, `contagem`=0. Separately, `rst_n` low mid-count -> all outputs 0 asynchronously. Switch `sel_fonte` to 1 -> only ticks on B decrement.
